control_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit accumulator processor. It steps each instruction through FETCH, DECODE and EXECUTE. It drives the load, select and increment strobes for the instruction register, program counter, accumulator and register file, plus the ALU operation code. It sits directly upstream of the datapath and consumes the 4-bit opcode field (instr[7:4]) held in the instruction register. It keeps the zero/carry flag register used by conditional jumps.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/exec_decoder.sv | 66 ++++++
 rtl/control_sequencer.sv | 114 +++++++++++
 tb/tb_control_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit accumulator processor:
// opcodes, ALU operation codes and the sequencer state encoding.
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_HALT   = 3'b100
    } state_t;

    // True for the opcodes that drive the ALU and update the flags.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/exec_decoder.sv
// Combinational opcode-to-strobe decode used during EXEC.
// Conditional jumps are resolved here against the latched flags.
module exec_decoder
    import proc_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_flag_z,
    input  logic       i_flag_c,
    output logic       o_load_pc,
    output logic       o_sel_pc,
    output logic       o_load_acc,
    output logic       o_sel_acc,
    output logic       o_sel_alu,
    output logic       o_load_reg,
    output logic [3:0] o_alu_ctrl,
    output logic       o_is_alu,
    output logic       o_is_hlt
);

    // Decode the EXEC strobes; anything not named for an opcode stays 0.
    always_comb begin
        o_load_pc  = 1'b0;
        o_sel_pc   = 1'b0;
        o_load_acc = 1'b0;
        o_sel_acc  = 1'b0;
        o_sel_alu  = 1'b0;
        o_load_reg = 1'b0;
        o_alu_ctrl = ALU_ADD;
        o_is_alu   = is_alu_op(i_opcode);
        o_is_hlt   = (i_opcode == OP_HLT);
        case (i_opcode)
            OP_LDI: begin
                o_load_acc = 1'b1;
                o_sel_acc  = 1'b1;
            end
            OP_LDR: o_load_acc = 1'b1;
            OP_STR: o_load_reg = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                o_load_acc = 1'b1;
                o_sel_alu  = 1'b1;
            end
            OP_JMP: o_load_pc = 1'b1;
            OP_JZ: begin
                o_load_pc = i_flag_z;
                o_sel_pc  = i_flag_z;
            end
            OP_JC: begin
                o_load_pc = i_flag_c;
                o_sel_pc  = i_flag_c;
            end
            default: ;
        endcase
        case (i_opcode)
            OP_SUB:  o_alu_ctrl = ALU_SUB;
            OP_AND:  o_alu_ctrl = ALU_AND;
            OP_OR:   o_alu_ctrl = ALU_OR;
            OP_XOR:  o_alu_ctrl = ALU_XOR;
            OP_NOT:  o_alu_ctrl = ALU_NOT;
            OP_SHL:  o_alu_ctrl = ALU_SHL;
            OP_SHR:  o_alu_ctrl = ALU_SHR;
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the accumulator processor.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | load IR from instruction memory, PC+1
//   DECODE | opcode settles in IR, no strobes
//   EXEC   | opcode-specific strobes, flags captured on ALU ops
//   HALT   | stopped until reset
module control_sequencer
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       CLB,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       z,
    input  logic       c,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       SelPC,
    output logic       LoadAcc,
    output logic       SelAcc,
    output logic       SelALU,
    output logic       LoadReg,
    output logic [3:0] ALUCtrl,
    output logic [2:0] cycle_status,
    output logic       halted
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_flag_z;
    logic       r_flag_c;

    logic       w_load_pc;
    logic       w_sel_pc;
    logic       w_load_acc;
    logic       w_sel_acc;
    logic       w_sel_alu;
    logic       w_load_reg;
    logic [3:0] w_alu_ctrl;
    logic       w_is_alu;
    logic       w_is_hlt;

    exec_decoder u_exec_decoder (
        .i_opcode   (opcode),
        .i_flag_z   (r_flag_z),
        .i_flag_c   (r_flag_c),
        .o_load_pc  (w_load_pc),
        .o_sel_pc   (w_sel_pc),
        .o_load_acc (w_load_acc),
        .o_sel_acc  (w_sel_acc),
        .o_sel_alu  (w_sel_alu),
        .o_load_reg (w_load_reg),
        .o_alu_ctrl (w_alu_ctrl),
        .o_is_alu   (w_is_alu),
        .o_is_hlt   (w_is_hlt)
    );

    // State register.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Z/C flags: only the edge that ends an ALU-op EXEC updates them.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (r_state == ST_EXEC && w_is_alu) begin
            r_flag_z <= z;
            r_flag_c <= c;
        end
    end

    // Next-state and output decode from the registered state only.
    always_comb begin
        w_state_nxt  = r_state;
        LoadIR       = 1'b0;
        IncPC        = 1'b0;
        LoadPC       = 1'b0;
        SelPC        = 1'b0;
        LoadAcc      = 1'b0;
        SelAcc       = 1'b0;
        SelALU       = 1'b0;
        LoadReg      = 1'b0;
        ALUCtrl      = 4'b0000;
        cycle_status = r_state;
        halted       = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                LoadIR      = 1'b1;
                IncPC       = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                LoadPC      = w_load_pc;
                SelPC       = w_sel_pc;
                LoadAcc     = w_load_acc;
                SelAcc      = w_sel_acc;
                SelALU      = w_sel_alu;
                LoadReg     = w_load_reg;
                ALUCtrl     = w_is_alu ? w_alu_ctrl : 4'b0000;
                w_state_nxt = w_is_hlt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized instruction stream against a phase/flag reference model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       CLB = 1'b0;
    logic       start = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       z = 1'b0;
    logic       c = 1'b0;
    logic       LoadIR, IncPC, LoadPC, SelPC, LoadAcc, SelAcc, SelALU, LoadReg;
    logic [3:0] ALUCtrl;
    logic [2:0] cycle_status;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 halt.
    int         m_phase = 0;
    logic [3:0] m_op = 4'h0;
    logic       m_z = 1'b0;
    logic       m_c = 1'b0;

    control_sequencer dut (
        .clk(clk), .CLB(CLB), .start(start), .opcode(opcode), .z(z), .c(c),
        .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC), .SelPC(SelPC),
        .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .LoadReg(LoadReg),
        .ALUCtrl(ALUCtrl), .cycle_status(cycle_status), .halted(halted)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as
    // {LoadIR,IncPC,LoadPC,SelPC,LoadAcc,SelAcc,SelALU,LoadReg,ALUCtrl,status,halted}
    function automatic logic [15:0] model_out(input int ph, input logic [3:0] op,
                                              input logic fz, input logic fc);
        logic ir = 0, inc = 0, lpc = 0, spc = 0, la = 0, sa = 0, salu = 0, lr = 0;
        logic [3:0] alu = 4'd0;
        int opi = int'(op);
        if (ph == 1) begin
            ir = 1; inc = 1;
        end else if (ph == 3) begin
            if (opi == 1) begin la = 1; sa = 1; end
            else if (opi == 2) la = 1;
            else if (opi == 3) lr = 1;
            else if (opi >= 4 && opi <= 11) begin
                la = 1; salu = 1; alu = 4'(opi - 4);
            end
            else if (opi == 12) lpc = 1;
            else if (opi == 13 && fz) begin lpc = 1; spc = 1; end
            else if (opi == 14 && fc) begin lpc = 1; spc = 1; end
        end
        return {ir, inc, lpc, spc, la, sa, salu, lr, alu, 3'(ph), (ph == 4)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {LoadIR, IncPC, LoadPC, SelPC, LoadAcc, SelAcc, SelALU, LoadReg,
                ALUCtrl, cycle_status, halted};
    endfunction

    // One clock of stimulus: drive inputs after the falling edge, capture
    // expected and actual, then step the model across the next rising edge.
    task automatic drive_cycle(input logic st, input logic [3:0] op, input logic zi,
                               input logic ci, output logic [15:0] exp_v,
                               output logic [15:0] act_v);
        @(negedge clk);
        start = st;
        if (m_phase == 0 || m_phase == 1) begin
            opcode = op;
            m_op   = op;
        end
        z = zi;
        c = ci;
        #1;
        exp_v = model_out(m_phase, m_op, m_z, m_c);
        act_v = dut_vec();
        case (m_phase)
            0: m_phase = st ? 1 : 0;
            1: m_phase = 2;
            2: m_phase = 3;
            3: begin
                if (m_op >= 4'h4 && m_op <= 4'hB) begin
                    m_z = zi;
                    m_c = ci;
                end
                m_phase = (m_op == 4'hF) ? 4 : 1;
            end
            default: m_phase = 4;
        endcase
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] e, a;
        CLB = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec() !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_hold got=%h want=%h", dut_vec(), 16'h0000);
            end
        end
        CLB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, e, a);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL idle_no_start cyc=%0d got=%h want=%h", i, a, e);
            end
        end
    endtask

    task automatic test_start();
        logic [15:0] e, a;
        drive_cycle(1'b1, 4'h1, 1'b0, 1'b0, e, a);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL start_idle got=%h want=%h", a, e);
        end
        drive_cycle(1'b0, 4'h1, 1'b0, 1'b0, e, a);
        n_tests++;
        if (a !== e || a[15:14] !== 2'b11 || a[3:1] !== 3'b001) begin
            n_fail++;
            $display("FAIL start_fetch got=%h want=%h", a, e);
        end
    endtask

    // Finishes the LDI fetched above, then a full LDI instruction.
    task automatic test_ldi();
        logic [15:0] e, a;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 4'h1, 1'b1, 1'b1, e, a);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ldi cyc=%0d got=%h want=%h", i, a, e);
            end
        end
    endtask

    task automatic test_flags_jz();
        logic [15:0] e, a;
        logic [3:0] prog [3] = '{4'h4, 4'hD, 4'hE};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b0, prog[k], (k == 0), 1'b0, e, a);
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL flags_jz op=%h cyc=%0d got=%h want=%h", prog[k], i, a, e);
                end
            end
    endtask

    task automatic test_ldr_hold();
        logic [15:0] e, a;
        logic [3:0] prog [3] = '{4'h4, 4'h2, 4'hD};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b0, prog[k], (k != 0), 1'b1, e, a);
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ldr_hold op=%h cyc=%0d got=%h want=%h", prog[k], i, a, e);
                end
            end
    endtask

    task automatic test_random();
        logic [15:0] e, a;
        logic [3:0] op;
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 14));
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'($urandom), op, 1'($urandom), 1'($urandom), e, a);
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL random op=%h cyc=%0d got=%h want=%h", op, i, a, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [15:0] e, a;
        logic [3:0] prog [2] = '{4'hD, 4'hE};
        // Prime the flags to 1 with an ADD, then interrupt a SUB.
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'h4, 1'b1, 1'b1, e, a);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 4'h5, 1'b1, 1'b1, e, a);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL sub_pre_reset cyc=%0d got=%h want=%h", i, a, e);
            end
        end
        // Still inside SUB's EXEC cycle: reset asynchronously.
        #1;
        CLB = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec() !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", dut_vec(), 16'h0000);
        end
        @(negedge clk);
        CLB = 1'b1;
        drive_cycle(1'b1, 4'hD, 1'b1, 1'b1, e, a);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b0, prog[k], 1'b1, 1'b1, e, a);
                n_tests++;
                if (a !== e || a[13] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_flags op=%h cyc=%0d got=%h want=%h", prog[k], i, a, e);
                end
            end
    endtask

    task automatic test_halt();
        logic [15:0] e, a;
        for (int i = 0; i < 13; i++) begin
            drive_cycle(1'b1, 4'hF, 1'b0, 1'b0, e, a);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL halt cyc=%0d got=%h want=%h", i, a, e);
            end
        end
        n_tests++;
        if (cycle_status !== 3'b100 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_final status=%b halted=%b want status=100 halted=1",
                     cycle_status, halted);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ldi();
        test_flags_jz();
        test_ldr_hold();
        test_random();
        test_reset_mid_exec();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
